// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the upstream fetch/regfile side, the issue stage and the execute ALU.
// The stage binds to the slave modport; the environment (or testbench) drives through master.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 10
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_in0;
    logic [DATA_W-1:0] out_in1;
    logic [SEL_W-1:0]  out_selector;
    logic [4:0]        out_rd;
    logic              out_we;
    logic              out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
        output fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_in0, out_in1, out_selector, out_rd, out_we, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
        input  fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_in0, out_in1, out_selector, out_rd, out_we, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the execute ALU through a 2-entry skid buffer.
// Define ALU_ISSUE_FWD_EN to let the writeback bypass override rs1/rs2 data at accept time.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 10
) (
    input logic             clk,
    input logic             rst,
    alu_issue_stage_if.slave bus
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic [SEL_W-1:0]  sel;
        logic [4:0]        rd;
        logic              we;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q;
    entry_t            head_q;
    entry_t            skid_q;
    logic              outValid_q;
    logic              inReady_q;
    entry_t            decoded_d;
    logic [DATA_W-1:0] rs1Val;
    logic [DATA_W-1:0] rs2Val;
    logic              accept;
    logic              xfer;

    logic [6:0]        opcode;
    logic [4:0]        rdIdx;
    logic [2:0]        funct3;
    logic [4:0]        rs1Idx;
    logic [4:0]        rs2Idx;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] immI;
    logic [DATA_W-1:0] immU;
    logic [DATA_W-1:0] shamt;

    assign opcode = bus.in_instr[6:0];
    assign rdIdx  = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1Idx = bus.in_instr[19:15];
    assign rs2Idx = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];
    assign immI   = DATA_W'($signed(bus.in_instr[31:20]));
    assign immU   = DATA_W'({bus.in_instr[31:12], 12'b0});
    assign shamt  = DATA_W'(bus.in_instr[24:20]);

    // x0 is forced to zero last so neither the regfile nor the bypass can make it non-zero.
    always_comb begin
        rs1Val = bus.in_rs1_data;
        rs2Val = bus.in_rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        if (bus.fwd_valid && (bus.fwd_rd == rs1Idx)) rs1Val = bus.fwd_data;
        if (bus.fwd_valid && (bus.fwd_rd == rs2Idx)) rs2Val = bus.fwd_data;
`endif
        if (rs1Idx == 5'd0) rs1Val = '0;
        if (rs2Idx == 5'd0) rs2Val = '0;
    end

`ifndef ALU_ISSUE_FWD_EN
    logic unusedFwd;
    assign unusedFwd = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data};
`endif

    always_comb begin
        decoded_d = '0;
        case (opcode)
            OP_R: begin
                decoded_d.in0 = rs1Val;
                decoded_d.in1 = rs2Val;
                decoded_d.sel = SEL_W'({funct7, funct3});
                decoded_d.we  = 1'b1;
            end
            OP_IMM: begin
                decoded_d.in0 = rs1Val;
                decoded_d.we  = 1'b1;
                case (funct3)
                    3'b001: begin
                        decoded_d.in1 = shamt;
                        decoded_d.sel = SEL_W'(10'b0000000001);
                    end
                    3'b101: begin
                        decoded_d.in1 = shamt;
                        decoded_d.sel = SEL_W'({funct7, 3'b101});
                    end
                    default: begin
                        decoded_d.in1 = immI;
                        decoded_d.sel = SEL_W'({7'b0, funct3});
                    end
                endcase
            end
            OP_LUI: begin
                decoded_d.in1 = immU;
                decoded_d.we  = 1'b1;
            end
            OP_AUIPC: begin
                decoded_d.in0 = bus.in_pc;
                decoded_d.in1 = immU;
                decoded_d.we  = 1'b1;
            end
            default: begin
                decoded_d.illegal = 1'b1;
            end
        endcase
        decoded_d.rd = rdIdx;
        if (rdIdx == 5'd0) decoded_d.we = 1'b0;
    end

    assign accept = bus.in_valid && inReady_q;
    assign xfer   = outValid_q && bus.out_ready;

    // head_q always drives out_*; skid_q only holds the second entry while FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
        end else if (bus.flush) begin
            state_q    <= EMPTY;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q     <= decoded_d;
                        state_q    <= ONE;
                        outValid_q <= 1'b1;
                        inReady_q  <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, xfer})
                        2'b10: begin
                            skid_q    <= decoded_d;
                            state_q   <= FULL;
                            inReady_q <= 1'b0;
                        end
                        2'b01: begin
                            state_q    <= EMPTY;
                            outValid_q <= 1'b0;
                        end
                        2'b11: begin
                            head_q <= decoded_d;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    if (xfer) begin
                        head_q    <= skid_q;
                        state_q   <= ONE;
                        inReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = inReady_q;
    assign bus.out_valid    = outValid_q;
    assign bus.out_in0      = head_q.in0;
    assign bus.out_in1      = head_q.in1;
    assign bus.out_selector = head_q.sel;
    assign bus.out_rd       = head_q.rd;
    assign bus.out_we       = head_q.we;
    assign bus.out_illegal  = head_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage directly upstream of the 32-bit execute ALU.
- Accepts one RV32I integer instruction per cycle with its PC and register-file read data.
- Decodes it into the ALU operand pair, the 10-bit ALU selector {funct7, funct3}, the destination register and the write enable.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides, so back-pressure from execute never creates a combinational ready path.

Parameters:
- DATA_W, 32, operand width; must match the ALU.
- SEL_W, 10, selector width; [9:3] carries funct7, [2:0] carries funct3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered entries; any same-cycle input is dropped.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven from a register only.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_W  instruction PC.
- in_rs1_data  in  DATA_W  register-file read of rs1.
- in_rs2_data  in  DATA_W  register-file read of rs2.
- fwd_valid  in  1  writeback bypass valid.
- fwd_rd  in  5  writeback destination register.
- fwd_data  in  DATA_W  writeback data.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  ALU/execute can consume.
- out_in0  out  DATA_W  ALU operand 0.
- out_in1  out  DATA_W  ALU operand 1.
- out_selector  out  SEL_W  ALU selector.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset values: all state clears synchronously.
  - Outputs: out_valid=0, all out_* data=0, in_ready=1.
  - Occupancy state is EMPTY.
- Transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency: an accepted instruction appears on out_* the following cycle when the buffer was EMPTY.
- Occupancy FSM:
  - EMPTY: accept -> ONE.
  - ONE: accept with no transfer -> FULL; transfer with no accept -> EMPTY; accept and transfer -> ONE.
  - FULL: transfer -> ONE. in_ready=0 in FULL.
- Ordering:
  - Strict FIFO; the head entry drives out_*.
  - While out_valid=1 and out_ready=0, out_* is held stable.
- Flush:
  - Next cycle state is EMPTY, out_valid=0 and in_ready=1.
  - The flush wins over a simultaneous accept or transfer.
- Register x0: an operand read from x0 is forced to 0 regardless of in_rs*_data.
- Decode (sel = out_selector, imm sign-extended to DATA_W):
  - opcode 0110011 (R): in0=rs1, in1=rs2, sel={funct7, funct3}, we=1.
  - opcode 0010011 (I-ALU): in0=rs1, in1=imm[11:0], sel={7'b0, funct3}, we=1.
    - Exception, funct3=101: sel={instr[31:25], 101} and in1={27'b0, instr[24:20]}.
    - Exception, funct3=001: in1={27'b0, instr[24:20]} and sel=10'b0000000001.
  - opcode 0110111 (LUI): in0=0, in1={instr[31:12], 12'b0}, sel=0, we=1.
  - opcode 0010111 (AUIPC): in0=in_pc, in1={instr[31:12], 12'b0}, sel=0, we=1.
  - Any other opcode: illegal=1, we=0, in0=in1=0, sel=0. The entry is still issued.
- out_rd = instr[11:7] for every opcode. out_we=0 whenever rd=0.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: at accept time, rs1/rs2 data is replaced by fwd_data when fwd_valid && fwd_rd==rs && rs!=0. Forwarding is evaluated per operand independently.
- Undefined: the fwd_* ports still exist but are ignored, and operands come only from in_rs*_data.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_in0=5, out_in1=7, out_selector=0x000, out_rd=3, out_we=1.
- SUB (0x402081B3), rs1=9, rs2=4 -> out_selector=0x100, out_in0=9, out_in1=4. SRAI x5,x6,4 (0x40435293) -> out_selector=0x105, out_in1=4.
- ADDI x1,x0,-1 (0xFFF00093), in_rs1_data=0xDEADBEEF -> out_in0=0, out_in1=0xFFFFFFFF. LUI x2,0x12345 (0x12345137) -> out_in0=0, out_in1=0x12345000. Opcode 0x7F -> out_illegal=1, out_we=0.
- Hold out_ready=0 and offer 3 back-to-back instructions -> in_ready=0 after 2 accepts and the third is held upstream. Release out_ready -> all 3 issue in order with no loss or duplication.
- Buffer FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1 and the input is not issued. Assert rst with 1 entry held -> same result.
- With ALU_ISSUE_FWD_EN: ADD x3,x1,x2 with fwd_valid=1, fwd_rd=1, fwd_data=0x55, in_rs1_data=0 -> out_in0=0x55. Same test with fwd_rd=0 -> out_in0=0. Same test with the macro undefined -> out_in0=0.
